block_window_scanner: RTL and testbench

- Per-frame stage directly upstream of the 3D block selector.
- On each start pulse it scans the time-sorted block chart in BRAM and collects up to 12 upcoming blocks whose hit time lies inside a look-ahead window.
- It converts each block's time offset into a z depth and publishes the 12-slot arrays (x, y, z, color, direction, ID, visible) that the selector consumes.
- Outputs are double-buffered: they change only at publish, so downstream sees stable block positions for a whole frame.

---
 rtl/block_pkg.sv | 46 ++++
 rtl/block_chart_decoder.sv | 37 +++
 rtl/block_window_scanner.sv | 160 ++++++++++++++++
 tb/tb_block_window_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_pkg.sv
// Shared chart word layout, slot record and state encodings for the block
// window scanner and the downstream 3D block selector.
package block_pkg;

  localparam int NUM_SLOTS = 12;
  localparam int TIME_W    = 18;
  localparam int X_W       = 12;
  localparam int Y_W       = 12;
  localparam int Z_W       = 14;
  localparam int DIR_W     = 3;
  localparam int ID_W      = 8;
  localparam int WORD_W    = 46;

  // Chart word: {time[45:28], x[27:16], y[15:4], color[3], dir[2:0]}
  localparam int TIME_LSB  = 28;
  localparam int X_LSB     = 16;
  localparam int Y_LSB     = 4;
  localparam int COLOR_BIT = 3;
  localparam int DIR_LSB   = 0;

  localparam logic [TIME_W-1:0] END_SENTINEL = 18'h3FFFF;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [Z_W-1:0]   z;
    logic             color;
    logic [DIR_W-1:0] dir;
    logic [ID_W-1:0]  id;
  } block_t;

  typedef enum logic [1:0] {
    CLS_EXPIRED,
    CLS_IN_WINDOW,
    CLS_BEYOND,
    CLS_SENTINEL
  } block_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_PUBLISH
  } scan_state_t;

endpackage

// File: rtl/block_chart_decoder.sv
// Combinational unpack of one chart word: field split, window classification
// and time-offset to z-depth conversion.
module block_chart_decoder
  import block_pkg::*;
#(
  parameter int WINDOW  = 4000,
  parameter int Z_SHIFT = 2
) (
  input  logic [WORD_W-1:0] word,
  input  logic [TIME_W-1:0] t_now,
  input  logic [ID_W-1:0]   id,
  output block_t            blk,
  output block_class_t      cls
);

  localparam logic [TIME_W-1:0] WIN = TIME_W'(WINDOW);

  logic [TIME_W-1:0] t_blk;
  logic [TIME_W-1:0] delta;

  always_comb begin
    t_blk     = word[TIME_LSB +: TIME_W];
    delta     = t_blk - t_now;
    blk.x     = word[X_LSB +: X_W];
    blk.y     = word[Y_LSB +: Y_W];
    blk.z     = Z_W'(delta << Z_SHIFT);
    blk.color = word[COLOR_BIT];
    blk.dir   = word[DIR_LSB +: DIR_W];
    blk.id    = id;
    // Sentinel wins over everything; delta is only meaningful once not expired.
    if (t_blk == END_SENTINEL)  cls = CLS_SENTINEL;
    else if (t_blk < t_now)     cls = CLS_EXPIRED;
    else if (delta >= WIN)      cls = CLS_BEYOND;
    else                        cls = CLS_IN_WINDOW;
  end

endmodule

// File: rtl/block_window_scanner.sv
// Per-frame scan of the time-sorted block chart; collects up to NUM_SLOTS
// in-window blocks into a shadow set and publishes it atomically.
module block_window_scanner
  import block_pkg::*;
#(
  parameter int NUM_BLOCKS   = 256,
  parameter int BRAM_LATENCY = 2,
  parameter int WINDOW       = 4000,
  parameter int Z_SHIFT      = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic [TIME_W-1:0]                 curr_time_in,
  output logic [ID_W-1:0]                   addr_out,
  input  logic [WORD_W-1:0]                 data_in,
  output logic                              busy_out,
  output logic                              done_out,
  output logic [TIME_W-1:0]                 curr_time_out,
  output logic [NUM_SLOTS-1:0][X_W-1:0]     block_x_out,
  output logic [NUM_SLOTS-1:0][Y_W-1:0]     block_y_out,
  output logic [NUM_SLOTS-1:0][Z_W-1:0]     block_z_out,
  output logic [NUM_SLOTS-1:0]              block_color_out,
  output logic [NUM_SLOTS-1:0][DIR_W-1:0]   block_direction_out,
  output logic [NUM_SLOTS-1:0][ID_W-1:0]    block_ID_out,
  output logic [NUM_SLOTS-1:0]              block_visible_out
);

  // state      | meaning
  // ST_IDLE    | waiting for start_in; published set held
  // ST_SCAN    | issuing addresses, classifying returned words
  // ST_DRAIN   | terminated; waiting for in-flight reads to retire unused
  // ST_PUBLISH | one cycle; shadow visible on outputs, done_out high

  localparam logic [ID_W-1:0] LAST_ADDR = ID_W'(NUM_BLOCKS - 1);
  localparam logic [3:0]      LAST_SLOT = 4'(NUM_SLOTS - 1);

  scan_state_t             state;
  logic [TIME_W-1:0]       t_now;
  logic                    issued;
  logic [BRAM_LATENCY-1:0] pv;
  logic [ID_W-1:0]         pid [BRAM_LATENCY];
  block_t                  shadow [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    shadow_vis;
  logic [3:0]              cnt;

  block_t       dec_blk;
  block_class_t dec_cls;
  logic         take;
  logic         accept;
  logic         term;

  block_chart_decoder #(
    .WINDOW  (WINDOW),
    .Z_SHIFT (Z_SHIFT)
  ) u_decoder (
    .word  (data_in),
    .t_now (t_now),
    .id    (pid[BRAM_LATENCY-1]),
    .blk   (dec_blk),
    .cls   (dec_cls)
  );

  always_comb begin
    take   = (state == ST_SCAN) && pv[BRAM_LATENCY-1];
    accept = take && (dec_cls == CLS_IN_WINDOW);
    term   = take && ((dec_cls == CLS_SENTINEL) || (dec_cls == CLS_BEYOND) ||
                      (pid[BRAM_LATENCY-1] == LAST_ADDR) ||
                      (accept && (cnt == LAST_SLOT)));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state               <= ST_IDLE;
      t_now               <= '0;
      issued              <= 1'b0;
      pv                  <= '0;
      cnt                 <= '0;
      shadow_vis          <= '0;
      addr_out            <= '0;
      busy_out            <= 1'b0;
      done_out            <= 1'b0;
      curr_time_out       <= '0;
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= '0;
      block_direction_out <= '0;
      block_ID_out        <= '0;
      block_visible_out   <= '0;
      for (int i = 0; i < BRAM_LATENCY; i++) pid[i] <= '0;
      for (int i = 0; i < NUM_SLOTS; i++)    shadow[i] <= '0;
    end else begin
      // Valid/ID tags track the address that was on addr_out last cycle.
      pv[0]  <= issued;
      pid[0] <= addr_out;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      done_out <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_in) begin
            t_now      <= curr_time_in;
            cnt        <= '0;
            shadow_vis <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
            addr_out   <= '0;
            issued     <= 1'b1;
            busy_out   <= 1'b1;
            state      <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (accept) begin
            shadow[cnt]     <= dec_blk;
            shadow_vis[cnt] <= 1'b1;
            cnt             <= cnt + 4'd1;
          end
          if (term) begin
            issued <= 1'b0;
            state  <= ST_DRAIN;
          end else if (addr_out != LAST_ADDR) begin
            addr_out <= addr_out + 1'b1;
          end else begin
            issued <= 1'b0;
          end
        end

        ST_DRAIN: begin
          if (pv == '0) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              block_x_out[i]         <= shadow[i].x;
              block_y_out[i]         <= shadow[i].y;
              block_z_out[i]         <= shadow[i].z;
              block_color_out[i]     <= shadow[i].color;
              block_direction_out[i] <= shadow[i].dir;
              block_ID_out[i]        <= shadow[i].id;
            end
            block_visible_out <= shadow_vis;
            curr_time_out     <= t_now;
            done_out          <= 1'b1;
            state             <= ST_PUBLISH;
          end
        end

        ST_PUBLISH: begin
          busy_out <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_window_scanner.sv
// Bench for block_window_scanner: behavioural BRAM + chart model, per-cycle
// output comparison and directed plus randomized frames.
module tb_block_window_scanner;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [17:0]          ctime = '0;
  logic [7:0]           addr;
  logic [45:0]          data;
  logic                 busy, done;
  logic [17:0]          ctout;
  logic [11:0][11:0]    bx, by;
  logic [11:0][13:0]    bz;
  logic [11:0]          bc;
  logic [11:0][2:0]     bd;
  logic [11:0][7:0]     bid;
  logic [11:0]          bv;

  logic [45:0] mem [256];
  logic [45:0] r1, r2;

  logic [11:0][11:0] pend_x, pend_y, exp_x, exp_y;
  logic [11:0][13:0] pend_z, exp_z;
  logic [11:0]       pend_c, exp_c, pend_v, exp_v;
  logic [11:0][2:0]  pend_d, exp_d;
  logic [11:0][7:0]  pend_id, exp_id;
  logic [17:0]       pend_t, exp_t;
  bit                frame_pending = 0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1 <= mem[addr];
    r2 <= r1;
  end
  assign data = r2;

  block_window_scanner dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .start_in            (start),
    .curr_time_in        (ctime),
    .addr_out            (addr),
    .data_in             (data),
    .busy_out            (busy),
    .done_out            (done),
    .curr_time_out       (ctout),
    .block_x_out         (bx),
    .block_y_out         (by),
    .block_z_out         (bz),
    .block_color_out     (bc),
    .block_direction_out (bd),
    .block_ID_out        (bid),
    .block_visible_out   (bv)
  );

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [45:0] mkw(input logic [17:0] t, input logic [11:0] x,
                                      input logic [11:0] y, input logic c, input logic [2:0] d);
    return {t, x, y, c, d};
  endfunction

  task automatic clear_model(output bit dummy);
    exp_x = '0; exp_y = '0; exp_z = '0; exp_c = '0; exp_d = '0; exp_id = '0; exp_v = '0;
    exp_t = '0;
    dummy = 1'b0;
  endtask

  // Reference: walk the chart in address order applying the window rules.
  task automatic compute(input logic [17:0] tn);
    int n;
    n = 0;
    pend_x = '0; pend_y = '0; pend_z = '0; pend_c = '0; pend_d = '0; pend_id = '0;
    pend_v = '0; pend_t = tn;
    for (int a = 0; a < 256; a++) begin
      int t;
      int d;
      t = int'(mem[a][45:28]);
      if (t == 'h3FFFF) break;
      if (t < int'(tn)) continue;
      d = t - int'(tn);
      if (d >= 4000) break;
      pend_x[n]  = mem[a][27:16];
      pend_y[n]  = mem[a][15:4];
      pend_z[n]  = 14'((d * 4) % 16384);
      pend_c[n]  = mem[a][3];
      pend_d[n]  = mem[a][2:0];
      pend_id[n] = 8'(a);
      pend_v[n]  = 1'b1;
      n++;
      if (n == 12) break;
    end
  endtask

  always @(negedge clk) begin
    logic eb;
    eb = frame_pending;
    if (done) begin
      chk("done_expected", 192'(frame_pending), 192'(1));
      exp_x = pend_x; exp_y = pend_y; exp_z = pend_z; exp_c = pend_c;
      exp_d = pend_d; exp_id = pend_id; exp_v = pend_v; exp_t = pend_t;
      frame_pending = 0;
    end
    chk("busy",    192'(busy),  192'(eb));
    chk("x",       192'(bx),    192'(exp_x));
    chk("y",       192'(by),    192'(exp_y));
    chk("z",       192'(bz),    192'(exp_z));
    chk("color",   192'(bc),    192'(exp_c));
    chk("dir",     192'(bd),    192'(exp_d));
    chk("id",      192'(bid),   192'(exp_id));
    chk("visible", 192'(bv),    192'(exp_v));
    chk("time",    192'(ctout), 192'(exp_t));
  end

  task automatic fill_sentinel();
    for (int a = 0; a < 256; a++) mem[a] = mkw(18'h3FFFF, 12'h0, 12'h0, 1'b0, 3'd0);
  endtask

  function automatic logic [45:0] blk_at(input int a, input logic [17:0] t);
    return mkw(t, 12'(a * 17 + 5), 12'(a * 29 + 3), a[0], 3'(a));
  endfunction

  // mode 0: plain; 1: extra start mid-scan; 2: start during the publish cycle
  task automatic run_frame(input logic [17:0] tn, input int mode);
    int n;
    bit seen;
    compute(tn);
    @(negedge clk); #1;
    frame_pending = 1;
    ctime = tn;
    start = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      #1;
      start = 1'b0;
      if (done) seen = 1;
      else if (mode == 1 && n == 20) begin
        ctime = tn ^ 18'h00155;
        start = 1'b1;
      end
    end
    chk("done_seen", 192'(seen), 192'(1));
    checks++;
    if (n > 261) begin
      errors++;
      $display("FAIL latency: %0d cycles, required at most 261", n);
    end
    if (mode == 2) begin
      ctime = tn + 18'd3;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    if (mode != 0) repeat (300) @(negedge clk);
  endtask

  initial begin
    bit d;
    clear_model(d);
    pend_x = '0; pend_y = '0; pend_z = '0; pend_c = '0; pend_d = '0; pend_id = '0;
    pend_v = '0; pend_t = '0;
    fill_sentinel();
    repeat (3) @(negedge clk);
    chk("rst_addr", 192'(addr), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    #1 rst_n = 1'b1;

    // Basic window
    fill_sentinel();
    mem[0] = blk_at(0, 18'd100);
    mem[1] = blk_at(1, 18'd500);
    mem[2] = blk_at(2, 18'd1000);
    mem[3] = blk_at(3, 18'd5000);
    run_frame(18'd200, 0);
    chk("basic_id0", 192'(bid[0]), 192'(1));
    chk("basic_z0",  192'(bz[0]),  192'(1200));
    chk("basic_id1", 192'(bid[1]), 192'(2));
    chk("basic_z1",  192'(bz[1]),  192'(3200));
    chk("basic_vis", 192'(bv),     192'(12'b11));
    chk("basic_t",   192'(ctout),  192'(200));

    // Saturation, with an ignored start during busy
    fill_sentinel();
    for (int a = 0; a < 20; a++) mem[a] = blk_at(a, 18'(300 + a));
    run_frame(18'd300, 1);
    chk("sat_vis",  192'(bv),      192'(12'hFFF));
    chk("sat_z1",   192'(bz[1]),   192'(4));
    chk("sat_id11", 192'(bid[11]), 192'(11));
    chk("sat_z11",  192'(bz[11]),  192'(44));

    // Window edge
    fill_sentinel();
    mem[0] = blk_at(0, 18'd4999);
    mem[1] = blk_at(1, 18'd5000);
    mem[2] = blk_at(2, 18'd5001);
    run_frame(18'd1000, 0);
    chk("edge_vis", 192'(bv),    192'(1));
    chk("edge_z0",  192'(bz[0]), 192'(15996));

    // Block exactly at t_now; start coincident with publish ignored
    fill_sentinel();
    mem[0] = blk_at(0, 18'd999);
    mem[1] = blk_at(1, 18'd1000);
    mem[2] = blk_at(2, 18'd1002);
    run_frame(18'd1000, 2);
    chk("now_id0", 192'(bid[0]), 192'(1));
    chk("now_z0",  192'(bz[0]),  192'(0));
    chk("now_z1",  192'(bz[1]),  192'(8));

    // Full chart, only the last entry live
    for (int a = 0; a < 255; a++) mem[a] = blk_at(a, 18'd10);
    mem[255] = blk_at(255, 18'd5010);
    run_frame(18'd5000, 0);
    chk("full_id0", 192'(bid[0]), 192'(255));
    chk("full_z0",  192'(bz[0]),  192'(40));
    chk("full_vis", 192'(bv),     192'(1));
    chk("full_addr_hold", 192'(addr), 192'(255));

    // Randomized sorted charts
    for (int f = 0; f < 8; f++) begin
      int base, t, sp;
      base = int'($urandom_range(0, 60000));
      sp = int'($urandom_range(3, 300));
      t = base;
      for (int a = 0; a < 256; a++) begin
        t = t + int'($urandom_range(0, 700));
        if (a >= sp) mem[a] = mkw(18'h3FFFF, 12'h0, 12'h0, 1'b0, 3'd0);
        else mem[a] = mkw(18'(t), 12'($urandom), 12'($urandom), 1'($urandom), 3'($urandom));
      end
      run_frame(18'(base + int'($urandom_range(0, 3000))), 0);
    end

    // Asynchronous reset mid-scan after ~5 accepts
    fill_sentinel();
    for (int a = 0; a < 20; a++) mem[a] = blk_at(a, 18'(300 + a));
    compute(18'd300);
    @(negedge clk); #1;
    frame_pending = 1;
    ctime = 18'd300;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    frame_pending = 0;
    clear_model(d);
    #1;
    chk("rst_async_vis",  192'(bv),  192'(0));
    chk("rst_async_id",   192'(bid), 192'(0));
    chk("rst_async_x",    192'(bx),  192'(0));
    chk("rst_async_busy", 192'(busy), 192'(0));
    chk("rst_async_addr", 192'(addr), 192'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
